// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: opcodes, queue entry layout and immediate decoders for fetch.
package instruction_fetch_pkg;
  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic comp;
    logic pred;
  } iq_entry_t;
  localparam int IQ_ENTRY_W = $bits(iq_entry_t);
  function automatic logic [31:0] j_imm(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
  function automatic logic [31:0] b_imm(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/instruction_fetch_inst_queue.sv
// instruction_fetch_inst_queue: circular FIFO with clear; pointers wrap on power-of-two depth.
module instruction_fetch_inst_queue #(
  parameter int W = 66,
  parameter int DEPTH_LOG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [DEPTH_LOG:0] count
);
  localparam int CW = DEPTH_LOG + 1;
  localparam int DEPTH = 1 << DEPTH_LOG;
  logic [W-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push & ~full;
    do_pop = pop & ~empty;
    head_d = clr ? '0 : head_q + DEPTH_LOG'(do_pop);
    tail_d = clr ? '0 : tail_q + DEPTH_LOG'(do_push);
    count_d = clr ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (do_push & ~clr) mem_q[tail_q] <= din;
  assign dout = mem_q[head_q];
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, single-outstanding fetch requester with static next-PC
// prediction, feeding an instruction queue toward issue.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int IQ_DEPTH_LOG = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic rdy_in,
  input  logic flush,
  input  logic [31:0] flush_pc,
  output logic fetch_en,
  output logic [31:0] fetch_addr,
  input  logic fetch_rdy,
  input  logic [31:0] fetch_data,
  input  logic fetch_is_compressed,
  output logic iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic iq_is_compressed,
  output logic iq_pred_taken,
  input  logic iq_pop
);
  localparam int CW = IQ_DEPTH_LOG + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1 << IQ_DEPTH_LOG);
  logic [31:0] pc_q, pc_d, pc_next;
  logic fetch_en_q, fetch_en_d;
  logic clr, push, pop, full, empty, is_jal, is_bt;
  logic [CW-1:0] count, count_post;
  iq_entry_t wr_entry, rd_entry, head;
  always_comb begin
    clr = rdy_in & flush;
    push = rdy_in & ~flush & fetch_en_q & fetch_rdy & ~full;
    pop = rdy_in & ~flush & iq_pop & ~empty;
    is_jal = fetch_data[6:0] == OPCODE_JAL;
    is_bt = fetch_data[6:0] == OPCODE_BRANCH && fetch_data[31];
    pc_next = pc_q + (is_jal ? j_imm(fetch_data) : is_bt ? b_imm(fetch_data) :
                      fetch_is_compressed ? 32'd2 : 32'd4);
    count_post = count + CW'(push) - CW'(pop);
    pc_d = clr ? flush_pc : push ? pc_next : pc_q;
    // A live request never sees a full queue, so the post-update count alone decides arming.
    fetch_en_d = rdy_in ? ~flush & (count_post < DEPTH) : fetch_en_q;
    wr_entry = '{inst: fetch_data, pc: pc_q, comp: fetch_is_compressed, pred: is_jal | is_bt};
    head = empty ? '0 : rd_entry;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      pc_q <= RESET_PC;
      fetch_en_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      fetch_en_q <= fetch_en_d;
    end
  instruction_fetch_inst_queue #(.W(IQ_ENTRY_W), .DEPTH_LOG(IQ_DEPTH_LOG)) u_iq (
    .clk(clk_in),
    .rst_n(rst_n_in),
    .clr(clr),
    .push(push),
    .pop(pop),
    .din(wr_entry),
    .dout(rd_entry),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign fetch_en = fetch_en_q;
  assign fetch_addr = pc_q;
  assign iq_valid = ~empty;
  assign iq_inst = head.inst;
  assign iq_pc = head.pc;
  assign iq_is_compressed = head.comp;
  assign iq_pred_taken = head.pred;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch requests, prediction, queue, flush, pause and reset.
module tb_instruction_fetch;
  logic clk_in = 0, rst_n_in = 0, rdy_in = 1, flush = 0, fetch_rdy = 0, fetch_is_compressed = 0, iq_pop = 0;
  logic [31:0] flush_pc = 0, fetch_data = 0;
  logic fetch_en, iq_valid, iq_is_compressed, iq_pred_taken;
  logic [31:0] fetch_addr, iq_inst, iq_pc;
  int n_chk = 0, n_err = 0;
  instruction_fetch #(.RESET_PC(32'h0), .IQ_DEPTH_LOG(2)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush(flush), .flush_pc(flush_pc),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_rdy(fetch_rdy), .fetch_data(fetch_data),
    .fetch_is_compressed(fetch_is_compressed), .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
    .iq_is_compressed(iq_is_compressed), .iq_pred_taken(iq_pred_taken), .iq_pop(iq_pop)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic respond(input logic [31:0] d, input logic c);
    int n = 0;
    while (!fetch_en && n < 10) begin
      tick();
      n++;
    end
    chk("req_seen", {31'b0, fetch_en}, 32'd1);
    fetch_data = d;
    fetch_is_compressed = c;
    fetch_rdy = 1;
    tick();
    fetch_rdy = 0;
  endtask
  task automatic pop1();
    iq_pop = 1;
    tick();
    iq_pop = 0;
  endtask
  initial begin
    #3;
    chk("rst_en", {31'b0, fetch_en}, 0);
    chk("rst_valid", {31'b0, iq_valid}, 0);
    chk("rst_addr", fetch_addr, 0);
    chk("rst_iq_pc", iq_pc, 0);
    chk("rst_iq_inst", iq_inst, 0);
    #3 rst_n_in = 1;
    tick();
    chk("first_en", {31'b0, fetch_en}, 1);
    chk("first_addr", fetch_addr, 0);
    respond(32'h00100093, 0);
    chk("r0_iq_pc", iq_pc, 0);
    chk("r0_iq_inst", iq_inst, 32'h00100093);
    chk("r0_addr", fetch_addr, 4);
    chk("r0_pred", {31'b0, iq_pred_taken}, 0);
    pop1();
    respond(32'h00000013, 1);
    chk("c_addr", fetch_addr, 6);
    chk("c_flag", {31'b0, iq_is_compressed}, 1);
    chk("c_iq_pc", iq_pc, 4);
    pop1();
    respond(32'h0100006F, 0);
    chk("jal_addr", fetch_addr, 22);
    chk("jal_pred", {31'b0, iq_pred_taken}, 1);
    chk("jal_iq_pc", iq_pc, 6);
    pop1();
    respond(32'hFE000CE3, 0);
    chk("beq_addr", fetch_addr, 14);
    chk("beq_pred", {31'b0, iq_pred_taken}, 1);
    pop1();
    chk("empty_valid", {31'b0, iq_valid}, 0);
    respond(32'h000080E7, 0);
    chk("jalr_addr", fetch_addr, 18);
    chk("jalr_pred", {31'b0, iq_pred_taken}, 0);
    respond(32'h00000463, 0);
    chk("fwd_addr", fetch_addr, 22);
    respond(32'h00100093, 0);
    chk("f3_en", {31'b0, fetch_en}, 1);
    respond(32'h00200093, 0);
    chk("full_en", {31'b0, fetch_en}, 0);
    chk("full_addr", fetch_addr, 30);
    chk("full_head", iq_pc, 14);
    tick();
    chk("full_hold_en", {31'b0, fetch_en}, 0);
    pop1();
    chk("rearm_en", {31'b0, fetch_en}, 1);
    chk("rearm_head", iq_pc, 18);
    chk("fwd_pred", {31'b0, iq_pred_taken}, 0);
    chk("rearm_addr", fetch_addr, 30);
    flush = 1;
    flush_pc = 32'h100;
    fetch_rdy = 1;
    fetch_data = 32'h00300093;
    iq_pop = 1;
    tick();
    flush = 0;
    fetch_rdy = 0;
    iq_pop = 0;
    chk("fl_valid", {31'b0, iq_valid}, 0);
    chk("fl_en", {31'b0, fetch_en}, 0);
    chk("fl_addr", fetch_addr, 32'h100);
    tick();
    chk("fl2_en", {31'b0, fetch_en}, 1);
    chk("fl2_addr", fetch_addr, 32'h100);
    chk("fl2_valid", {31'b0, iq_valid}, 0);
    respond(32'h00400093, 0);
    chk("pf_addr", fetch_addr, 32'h104);
    chk("pf_iq_pc", iq_pc, 32'h100);
    rdy_in = 0;
    iq_pop = 1;
    fetch_data = 32'h0100006F;
    for (int i = 0; i < 5; i++) begin
      fetch_rdy = ~fetch_rdy;
      tick();
      chk("pause_addr", fetch_addr, 32'h104);
      chk("pause_en", {31'b0, fetch_en}, 1);
      chk("pause_valid", {31'b0, iq_valid}, 1);
      chk("pause_iq_pc", iq_pc, 32'h100);
      chk("pause_inst", iq_inst, 32'h00400093);
    end
    rdy_in = 1;
    iq_pop = 0;
    fetch_rdy = 0;
    #2 rst_n_in = 0;
    #1;
    chk("arst_en", {31'b0, fetch_en}, 0);
    chk("arst_valid", {31'b0, iq_valid}, 0);
    chk("arst_addr", fetch_addr, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Owns the program counter and drives the decoder-side request port of the memory control block (enable/address held until ready; ready and data valid for exactly one cycle). Each returned instruction, already expanded to 32 bits with a compressed flag, is pushed with its PC into a small instruction queue for the issue stage. Next-PC prediction is static:
- JAL is followed.
- Backward conditional branches are taken.
- Everything else falls through.

A flush from commit redirects fetch.

## Interface
- `RESET_PC`, 32'h0, PC loaded at reset.
- `IQ_DEPTH_LOG`, 2, log2 of instruction queue depth (depth 4).
- `clk_in`  in  1  clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global pause; when low, no state changes.
- `flush`  in  1  redirect request, valid only with `rdy_in`.
- `flush_pc`  in  32  redirect target.
- `fetch_en`  out  1  request to memory control.
- `fetch_addr`  out  32  PC of the requested instruction.
- `fetch_rdy`  in  1  response valid, one cycle.
- `fetch_data`  in  32  expanded instruction.
- `fetch_is_compressed`  in  1  original encoding was 16-bit.
- `iq_valid`  out  1  queue head valid.
- `iq_inst`  out  32  head instruction.
- `iq_pc`  out  32  head PC.
- `iq_is_compressed`  out  1  head compressed flag.
- `iq_pred_taken`  out  1  head predicted taken.
- `iq_pop`  in  1  consumer takes head this cycle; ignored when `iq_valid` is 0.

## Operation
- **Registers:** `pc`, `fetch_en`, queue storage, and head, tail and count pointers.
- **Reset values:** `pc`=`RESET_PC`, `fetch_en`=0, count=0, all `iq_*` outputs 0.
- **Request rule:**
  - `fetch_addr` always equals `pc`.
  - Once `fetch_en` is 1, neither it nor `pc` changes until the `fetch_rdy` cycle, except on flush.
  - `fetch_en` rises only when count < depth.
  - Only one request is outstanding at a time.
- **Response (`fetch_rdy`=1, no flush):**
  - Push {`fetch_data`, `pc`, `fetch_is_compressed`, pred} into the queue.
  - Next `pc`:
    - JAL (opcode 1101111): `pc`+J-imm, pred=1.
    - Branch (1100011) with imm[12]=1: `pc`+B-imm, pred=1.
    - Otherwise: `pc`+2 if compressed, else `pc`+4, pred=0.
  - JALR is never predicted.
  - `fetch_en` stays 1 if post-push count < depth (the pop in the same cycle counts), else 0.
- **Queue:**
  - Circular buffer; pointers wrap modulo depth.
  - Push and pop in the same cycle leave count unchanged.
  - A pop when full frees a slot; fetch re-arms the next cycle.
- **Flush (`flush` && `rdy_in`):** has priority over everything.
  - `pc`=`flush_pc`, count=0, pointers=0, `fetch_en`=0.
  - A `fetch_rdy` in the same cycle is discarded.
  - `iq_pop` in the same cycle is ignored.
  - Fetch re-arms the following cycle.
- **Pause:** `rdy_in`=0 freezes all state, including on `fetch_rdy`. Memory control also only advances with `rdy_in`.
- **Arithmetic:** 32-bit, wrap-around on overflow. Immediates are sign-extended per RV32I.

## Timing
- Queue outputs are registered-read from storage; `iq_valid` = (count≠0).
- Head data appears the cycle after a push into an empty queue.
- **Redirect latency:** flush at edge N → `fetch_en`=1 with `fetch_addr`=`flush_pc` after edge N+1.
- **Back-to-back fetch:**
  - After the `fetch_rdy` edge, the next request is visible immediately.
  - Memory control's cooldown costs one idle cycle.
  - Minimum spacing on an instruction-cache hit: 3 cycles.
- Reset is asynchronous assert and synchronous release. Reset during an outstanding request drops it.

## Structure
- Opcode constants (`OPCODE_JAL`, `OPCODE_BRANCH`) and queue entry width go in `params.v` as macros alongside the existing width macros.
- Sub-module `inst_queue`: parameterised circular FIFO with push, pop, clear, full, empty and count.
- The top holds the PC, request logic and predictor.

## Test plan
- **Reset and first fetch:** release `rst_n_in` with `RESET_PC`=0 → `fetch_en`=1, `fetch_addr`=0. Respond 32'h00100093 uncompressed → `iq_pc`=0, `fetch_addr`=4.
- **Compressed and JAL prediction:**
  - Respond compressed at `pc` 4 → next `fetch_addr`=6.
  - Respond JAL imm=+16 at 6 → next `fetch_addr`=22, `iq_pred_taken`=1.
  - Respond BEQ imm=−8 at 22 → next `fetch_addr`=14, `iq_pred_taken`=1.
- **Queue full:** hold `iq_pop`=0 and answer 4 requests → `fetch_en`=0, count=4. Pulse `iq_pop` → `fetch_en` returns to 1 after the next edge, head PC advances.
- **Flush coincident with response:** `flush`=1, `flush_pc`=32'h100, and `fetch_rdy`=1 in the same cycle → queue empty, response not enqueued, `fetch_en`=1 with `fetch_addr`=32'h100 two edges later.
- **Pause:** `rdy_in`=0 for 5 cycles while `fetch_rdy` toggles → `pc`, count and outputs unchanged.
- **Asynchronous reset mid-request:** drop `rst_n_in` mid-clock while `fetch_en`=1 → `fetch_en`=0 and `iq_valid`=0 before the next edge.
